fir_tap_loader: RTL and testbench

//  Coefficient source for configurable_fir: holds a shadow copy of all T = 2**(N_LOG2+M_LOG2) taps.

---
 rtl/fir_tap_loader_pkg.sv | 21 ++
 rtl/fir_tap_mem.sv | 53 +++++
 rtl/fir_tap_loader.sv | 193 +++++++++++++++++++
 tb/tb_fir_tap_loader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tap_loader_pkg.sv
// -----------------------------------------------------------------------------
// fir_tap_loader_pkg
// Shared types and helpers for the FIR coefficient loader.
//   state_t   : loader FSM states
//   tap_count : total tap count T = 2**(n_log2 + m_log2)
// -----------------------------------------------------------------------------
package fir_tap_loader_pkg;

  typedef enum logic [1:0] {
    SM_IDLE    = 2'd0,
    SM_DISABLE = 2'd1,
    SM_PRIME   = 2'd2,
    SM_STREAM  = 2'd3
  } state_t;

  function automatic int unsigned tap_count(input int unsigned n_log2,
                                            input int unsigned m_log2);
    return 32'd1 << (n_log2 + m_log2);
  endfunction

endpackage

// File: rtl/fir_tap_mem.sv
// -----------------------------------------------------------------------------
// fir_tap_mem
// Simple dual-port tap RAM: one write port, one synchronous read port with
// one cycle of latency. The array itself is not reset; only the read-data
// register is cleared so the downstream tap bus is quiet after reset.
// Ports:
//   clk_i      clock
//   rst_n_i    async active-low reset (read register only)
//   wr_en_i    write strobe
//   wr_addr_i  write index
//   wr_data_i  write value
//   rd_addr_i  read index, sampled on the rising edge
//   rd_data_o  mem[rd_addr_i] from the previous edge
// -----------------------------------------------------------------------------
module fir_tap_mem #(
  parameter int unsigned G_ADDR_WIDTH = 4,
  parameter int unsigned G_DATA_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    wr_en_i,
  input  logic [G_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [G_DATA_WIDTH-1:0] wr_data_i,
  input  logic [G_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [G_DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** G_ADDR_WIDTH;

  logic [G_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [G_DATA_WIDTH-1:0] rd_data_q;

  // Write port: commit one tap per strobe
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end else begin
      mem_q[wr_addr_i] <= mem_q[wr_addr_i];
    end
  end

  // Read port: registered read, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= {G_DATA_WIDTH{1'b0}};
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_tap_loader.sv
// -----------------------------------------------------------------------------
// fir_tap_loader
// Coefficient source for configurable_fir. Keeps a shadow copy of all
// T = 2**(G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2) taps, written by software
// through cfg_wr_*. On start it disables the FIR for G_DISABLE_CYCLES cycles,
// primes the RAM read, then streams every tap in address order over a
// valid/ready interface, pulsing done after the last accepted tap.
// Optional feature macro: FIR_TAP_LOADER_CHECKSUM_EN adds tap_checksum, the
// signed running sum of the taps transferred in the current/last load.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   cfg_wr_addr/data/valid/ready  software tap write port (ready only in IDLE)
//   start                         one-cycle load request (ignored while busy)
//   busy, done                    status; done pulses once per load
//   fir_enable                    FIR enable, low only during DISABLE
//   tap_dout/valid/ready          tap stream to the FIR
//   tap_checksum                  (macro only) signed sum of streamed taps
// -----------------------------------------------------------------------------
module fir_tap_loader
  import fir_tap_loader_pkg::*;
#(
  parameter  int unsigned G_NUM_STAGES_LOG2  = 2,
  parameter  int unsigned G_STAGE_DEPTH_LOG2 = 2,
  parameter  int unsigned G_TAP_WIDTH        = 16,
  parameter  int unsigned G_DISABLE_CYCLES   = 2,
  localparam int unsigned AW = G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2,
  localparam int unsigned TW = G_TAP_WIDTH
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cfg_wr_addr,
  input  logic [TW-1:0] cfg_wr_data,
  input  logic          cfg_wr_valid,
  output logic          cfg_wr_ready,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fir_enable,
  output logic [TW-1:0] tap_dout,
  output logic          tap_dout_valid,
  input  logic          tap_dout_ready
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
  ,
  output logic [TW+AW-1:0] tap_checksum
`endif
);

  localparam int unsigned T  = tap_count(G_NUM_STAGES_LOG2, G_STAGE_DEPTH_LOG2);
  localparam int unsigned DW = $clog2(G_DISABLE_CYCLES + 1);

  localparam logic [AW-1:0] LAST_PTR = AW'(T - 1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [DW-1:0] DIS_LAST = DW'(G_DISABLE_CYCLES - 1);
  localparam logic [DW-1:0] DIS_ZERO = DW'(0);
  localparam logic [DW-1:0] DIS_ONE  = DW'(1);

  state_t        state_q;
  logic [AW-1:0] ptr_q;
  logic [DW-1:0] dis_cnt_q;
  logic          cfg_wr_ready_q;
  logic          busy_q;
  logic          done_q;
  logic          fir_enable_q;
  logic          tap_dout_valid_q;

  logic          wr_fire;
  logic          xfer_fire;
  logic [AW-1:0] rd_addr_d;

  assign wr_fire   = cfg_wr_valid & cfg_wr_ready_q;
  assign xfer_fire = tap_dout_valid_q & tap_dout_ready;

  // Look one tap ahead on a transfer so the RAM output always equals mem[ptr]
  always_comb begin
    rd_addr_d = ptr_q;
    if (xfer_fire) begin
      rd_addr_d = ptr_q + PTR_ONE;
    end else begin
      rd_addr_d = ptr_q;
    end
  end

  fir_tap_mem #(
    .G_ADDR_WIDTH (AW),
    .G_DATA_WIDTH (TW)
  ) u_mem (
    .clk_i     (clk),
    .rst_n_i   (reset_n),
    .wr_en_i   (wr_fire),
    .wr_addr_i (cfg_wr_addr),
    .wr_data_i (cfg_wr_data),
    .rd_addr_i (rd_addr_d),
    .rd_data_o (tap_dout)
  );

  // Loader FSM with registered status and handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= SM_IDLE;
      ptr_q            <= PTR_ZERO;
      dis_cnt_q        <= DIS_ZERO;
      cfg_wr_ready_q   <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      fir_enable_q     <= 1'b0;
      tap_dout_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SM_IDLE: begin
          // A write in this same cycle lands before PRIME reads, so it streams.
          if (start) begin
            state_q        <= SM_DISABLE;
            dis_cnt_q      <= DIS_ZERO;
            cfg_wr_ready_q <= 1'b0;
            busy_q         <= 1'b1;
            fir_enable_q   <= 1'b0;
          end else begin
            cfg_wr_ready_q <= 1'b1;
          end
        end
        SM_DISABLE: begin
          if (dis_cnt_q == DIS_LAST) begin
            state_q      <= SM_PRIME;
            fir_enable_q <= 1'b1;
            ptr_q        <= PTR_ZERO;
          end else begin
            dis_cnt_q <= dis_cnt_q + DIS_ONE;
          end
        end
        SM_PRIME: begin
          // Read of index 0 is in flight; data is ready when valid rises.
          state_q          <= SM_STREAM;
          tap_dout_valid_q <= 1'b1;
        end
        SM_STREAM: begin
          if (xfer_fire) begin
            if (ptr_q == LAST_PTR) begin
              state_q          <= SM_IDLE;
              tap_dout_valid_q <= 1'b0;
              done_q           <= 1'b1;
              busy_q           <= 1'b0;
              cfg_wr_ready_q   <= 1'b1;
              ptr_q            <= PTR_ZERO;
            end else begin
              ptr_q <= ptr_q + PTR_ONE;
            end
          end else begin
            ptr_q <= ptr_q;
          end
        end
        default: begin
          state_q          <= SM_IDLE;
          ptr_q            <= PTR_ZERO;
          dis_cnt_q        <= DIS_ZERO;
          cfg_wr_ready_q   <= 1'b0;
          busy_q           <= 1'b0;
          fir_enable_q     <= 1'b0;
          tap_dout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_wr_ready   = cfg_wr_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fir_enable     = fir_enable_q;
  assign tap_dout_valid = tap_dout_valid_q;

`ifdef FIR_TAP_LOADER_CHECKSUM_EN
  localparam int unsigned CW = TW + AW;

  logic [CW-1:0] checksum_q;

  // Signed running sum of streamed taps; held from done until the next PRIME
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= {CW{1'b0}};
    end else if (state_q == SM_PRIME) begin
      checksum_q <= {CW{1'b0}};
    end else if (xfer_fire) begin
      checksum_q <= checksum_q + {{AW{tap_dout[TW-1]}}, tap_dout};
    end else begin
      checksum_q <= checksum_q;
    end
  end

  assign tap_checksum = checksum_q;
`endif

endmodule

// File: tb/tb_fir_tap_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_tap_loader
// Self-checking bench for fir_tap_loader (default parameters, T = 16).
// A plain array holds the taps software has written; every load is expected
// to deliver exactly that array in order, whatever the ready pattern.
// -----------------------------------------------------------------------------
module tb_fir_tap_loader;

  localparam int T   = 16;
  localparam int TW  = 16;
  localparam int AW  = 4;
  localparam int DIS = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] cfg_wr_addr;
  logic [TW-1:0] cfg_wr_data;
  logic          cfg_wr_valid;
  logic          cfg_wr_ready;
  logic          start;
  logic          busy;
  logic          done;
  logic          fir_enable;
  logic [TW-1:0] tap_dout;
  logic          tap_dout_valid;
  logic          tap_dout_ready;
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
  logic [TW+AW-1:0] tap_checksum;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [TW-1:0] model_mem [T];

  fir_tap_loader #(
    .G_NUM_STAGES_LOG2  (2),
    .G_STAGE_DEPTH_LOG2 (2),
    .G_TAP_WIDTH        (TW),
    .G_DISABLE_CYCLES   (DIS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_data    (cfg_wr_data),
    .cfg_wr_valid   (cfg_wr_valid),
    .cfg_wr_ready   (cfg_wr_ready),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .fir_enable     (fir_enable),
    .tap_dout       (tap_dout),
    .tap_dout_valid (tap_dout_valid),
    .tap_dout_ready (tap_dout_ready)
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    ,
    .tap_checksum   (tap_checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic cfg_write(input logic [AW-1:0] a, input logic [TW-1:0] d);
    int n = 0;
    while (cfg_wr_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (cfg_wr_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL cfg_wr_ready_wait: got %b, expected 1 within 50 cycles", cfg_wr_ready);
    end
    cfg_wr_addr  = a;
    cfg_wr_data  = d;
    cfg_wr_valid = 1'b1;
    @(negedge clk);
    cfg_wr_valid = 1'b0;
    model_mem[a] = d;
  endtask

  // kind 0: 0x0100+k, kind 1: all 0xFFFF, otherwise random
  task automatic write_taps(input int kind);
    logic [TW-1:0] d;
    for (int k = 0; k < T; k++) begin
      if (kind == 0)      d = 16'h0100 + 16'(k);
      else if (kind == 1) d = 16'hFFFF;
      else                d = 16'($urandom);
      cfg_write(4'(k), d);
    end
  endtask

  // mode 0: ready always 1, 1: ready 1,0,0 repeating, 2: random ready.
  // abort_at >= 0 drops reset_n when that many taps have been transferred.
  task automatic do_load(input string tag, input int mode, input bit wr_with_start,
                         input bit inject, input int abort_at);
    logic [TW-1:0] got[$];
    logic [TW-1:0] prev_tap = 16'h0000;
    bit   prev_stall = 1'b0;
    bit   fe_high = 1'b0;
    bit   finished = 1'b0;
    int   fe_low = 0, first_x = -1, last_x = -1, done_n = 0, done_at = -1;
    int   stall_bad = 0, busy_bad = 0, ready_bad = 0;
    logic done_valid = 1'b1, done_busy = 1'b1, done_rdy = 1'b0, done_fe = 1'b0;
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    logic [TW+AW-1:0] cks_done = '0;
    logic [TW+AW-1:0] cks_exp;
    int   sum = 0;
`endif
    start = 1'b1;
    if (wr_with_start) begin
      cfg_wr_addr  = 4'd5;
      cfg_wr_data  = 16'hBEEF;
      cfg_wr_valid = 1'b1;
      model_mem[5] = 16'hBEEF;
    end
    @(negedge clk);
    start = 1'b0;
    cfg_wr_valid = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      if (done_at >= 0 && i >= done_at + 3) begin
        finished = 1'b1;
      end else begin
        if (!fe_high) begin
          if (fir_enable === 1'b1) fe_high = 1'b1;
          else fe_low++;
        end
        if (done === 1'b1) begin
          done_n++;
          if (done_at < 0) begin
            done_at = i; done_valid = tap_dout_valid; done_busy = busy;
            done_rdy = cfg_wr_ready; done_fe = fir_enable;
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
            cks_done = tap_checksum;
`endif
          end
        end
        if (done_at < 0) begin
          if (busy !== 1'b1) busy_bad++;
          if (cfg_wr_ready !== 1'b0) ready_bad++;
        end
        if (prev_stall && tap_dout_valid === 1'b1 && tap_dout !== prev_tap) stall_bad++;
        case (mode)
          0:       tap_dout_ready = 1'b1;
          1:       tap_dout_ready = (i % 3 == 0);
          default: tap_dout_ready = 1'($urandom_range(0, 1));
        endcase
        if (abort_at >= 0 && got.size() == abort_at && tap_dout_valid === 1'b1) begin
          reset_n = 1'b0;
          #1;
          vec_cnt++;
          if ({tap_dout_valid, busy, fir_enable, done, cfg_wr_ready} !== 5'b00000 || tap_dout !== 16'h0000) begin
            err_cnt++;
            $display("FAIL %s async_reset: valid,busy,fe,done,rdy=%b dout=%h, expected 00000 and 0000", tag,
                     {tap_dout_valid, busy, fir_enable, done, cfg_wr_ready}, tap_dout);
          end
          start = 1'b0;
          cfg_wr_valid = 1'b0;
          return;
        end
        if (tap_dout_valid === 1'b1 && tap_dout_ready) begin
          got.push_back(tap_dout);
          if (first_x < 0) first_x = i;
          last_x = i;
        end
        prev_stall = (tap_dout_valid === 1'b1) && !tap_dout_ready;
        prev_tap   = tap_dout;
        if (inject && tap_dout_valid === 1'b1) begin
          start        = 1'($urandom_range(0, 1));
          cfg_wr_valid = 1'b1;
          cfg_wr_addr  = 4'd0;
          cfg_wr_data  = 16'hFFFF;
        end else begin
          start        = 1'b0;
          cfg_wr_valid = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    cfg_wr_valid = 1'b0;
    vec_cnt++;
    if (done_at < 0) begin
      err_cnt++;
      $display("FAIL %s done_timeout: no done within 400 cycles, got %0d taps, expected 16", tag, got.size());
    end
    vec_cnt++;
    if (got.size() != T) begin
      err_cnt++;
      $display("FAIL %s tap_count: got %0d, expected %0d", tag, got.size(), T);
    end
    for (int k = 0; k < T && k < got.size(); k++) begin
      vec_cnt++;
      if (got[k] !== model_mem[k]) begin
        err_cnt++;
        $display("FAIL %s tap[%0d]: got %h, expected %h", tag, k, got[k], model_mem[k]);
      end
    end
    vec_cnt++;
    if (done_n != 1 || done_at != last_x + 1) begin
      err_cnt++;
      $display("FAIL %s done_pulse: count %0d at cycle %0d, expected 1 at cycle %0d", tag, done_n, done_at, last_x + 1);
    end
    vec_cnt++;
    if ({done_valid, done_busy, done_rdy, done_fe} !== 4'b0011) begin
      err_cnt++;
      $display("FAIL %s done_state: valid,busy,rdy,fe=%b, expected 0011", tag, {done_valid, done_busy, done_rdy, done_fe});
    end
    vec_cnt++;
    if (fe_low != DIS) begin
      err_cnt++;
      $display("FAIL %s fir_enable_low: got %0d cycles, expected %0d", tag, fe_low, DIS);
    end
    vec_cnt++;
    if (stall_bad != 0 || busy_bad != 0 || ready_bad != 0) begin
      err_cnt++;
      $display("FAIL %s stream_flags: unstable %0d, busy low %0d, wr_ready high %0d, expected 0 0 0",
               tag, stall_bad, busy_bad, ready_bad);
    end
    if (mode == 0) begin
      vec_cnt++;
      if (first_x != DIS + 1 || last_x != DIS + T) begin
        err_cnt++;
        $display("FAIL %s timing: transfers %0d..%0d, expected %0d..%0d", tag, first_x, last_x, DIS + 1, DIS + T);
      end
    end
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    for (int k = 0; k < T; k++) sum += int'($signed(model_mem[k]));
    cks_exp = (TW + AW)'(sum);
    vec_cnt++;
    if (cks_done !== cks_exp || tap_checksum !== cks_exp) begin
      err_cnt++;
      $display("FAIL %s checksum: at done %h, later %h, expected %h", tag, cks_done, tap_checksum, cks_exp);
    end
`endif
  endtask

  task automatic test_reset();
    #3;
    vec_cnt++;
    if ({cfg_wr_ready, busy, done, fir_enable, tap_dout_valid} !== 5'b00000 || tap_dout !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_values: rdy,busy,done,fe,valid=%b dout=%h, expected 00000 and 0000",
               {cfg_wr_ready, busy, done, fir_enable, tap_dout_valid}, tap_dout);
    end
`ifdef FIR_TAP_LOADER_CHECKSUM_EN
    vec_cnt++;
    if (tap_checksum !== 20'h00000) begin
      err_cnt++;
      $display("FAIL reset_checksum: got %h, expected 00000", tap_checksum);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (cfg_wr_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL ready_after_release: rdy=%b busy=%b, expected 1 0", cfg_wr_ready, busy);
    end
  endtask

  task automatic test_basic_load();
    write_taps(0);
    do_load("basic", 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stalled_load();
    do_load("stalled", 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_write_with_start();
    do_load("wr_with_start", 0, 1'b1, 1'b0, -1);
    vec_cnt++;
    if (model_mem[5] !== 16'hBEEF) begin
      err_cnt++;
      $display("FAIL wr_with_start_model: got %h, expected beef", model_mem[5]);
    end
  endtask

  task automatic test_ignored_inputs();
    do_load("ignored_inputs", 2, 1'b0, 1'b1, -1);
    // a follow-up load shows addr 0 kept its value
    do_load("after_ignored", 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_stream();
    write_taps(0);
    do_load("abort", 0, 1'b0, 1'b0, 7);
    @(negedge clk);
    vec_cnt++;
    if (fir_enable !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_held: fe=%b busy=%b, expected 0 0", fir_enable, busy);
    end
    reset_n = 1'b1;
    @(negedge clk);
    do_load("restart", 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_all_ones();
    write_taps(1);
    do_load("all_ones", 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 3; r++) begin
      write_taps(2);
      do_load("random", 2, 1'b0, 1'b0, -1);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    cfg_wr_valid   = 1'b0;
    cfg_wr_addr    = 4'd0;
    cfg_wr_data    = 16'h0000;
    tap_dout_ready = 1'b0;
    test_reset();
    test_basic_load();
    test_stalled_load();
    test_write_with_start();
    test_ignored_inputs();
    test_reset_mid_stream();
    test_all_ones();
    test_random_loads();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
